// File: rtl/cim_mem_top.sv
// Output-tile memory for the Winograd CIM array: two PE accumulate ports on a
// two-stage pipeline plus a whole-word scan load/dump port.
`timescale 1ns/1ps
module cim_mem_top #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned WORD_W = 512,
    parameter int unsigned LANE_W = 12,
    parameter int unsigned TILE   = 6
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic signed [0:TILE-1][0:TILE-1][LANE_W-1:0]  PE_tile_i_1,
    input  logic [7:0]                                    PE_od_i_1,
    input  logic [7:0]                                    PE_addr_i_1,
    input  logic                                          PE_valid_i_1,
    input  logic signed [0:TILE-1][0:TILE-1][LANE_W-1:0]  PE_tile_i_2,
    input  logic [7:0]                                    PE_od_i_2,
    input  logic [7:0]                                    PE_addr_i_2,
    input  logic                                          PE_valid_i_2,
    input  logic [WORD_W-1:0]                             scan_in,
    input  logic [7:0]                                    scan_addr,
    input  logic [1:0]                                    scan_mode,
    output logic [WORD_W-1:0]                             scan_out
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LANES  = TILE * TILE;
    localparam int unsigned TAG_LO = LANES * LANE_W;

    typedef enum logic [1:0] {
        MODE_SWR  = 2'b00,
        MODE_PE   = 2'b01,
        MODE_IDLE = 2'b10,
        MODE_SRD  = 2'b11
    } mode_e;

    typedef logic [0:TILE-1][0:TILE-1][LANE_W-1:0] tile_t;

    logic [WORD_W-1:0] mem_q [DEPTH];

    // S2 stage: sampled request plus the (forwarded) old word per port
    logic              s2_v1_q, s2_v2_q;
    logic [ADDR_W-1:0] s2_addr1_q, s2_addr2_q;
    logic [TAG_W-1:0]  s2_od1_q, s2_od2_q;
    tile_t             s2_tile1_q, s2_tile2_q;
    logic [WORD_W-1:0] s2_old1_q, s2_old2_q;

    logic              pe_mode_c, swr_c, srd_c, scan_ok_c;
    logic              v1_c, v2_c, both_c;
    logic [WORD_W-1:0] old1_c, old2_c;
    wire  [WORD_W-1:0] wr1_c, wr2_c;

    assign pe_mode_c = (scan_mode == MODE_PE);
    assign swr_c     = (scan_mode == MODE_SWR);
    assign srd_c     = (scan_mode == MODE_SRD);
    assign scan_ok_c = (scan_addr < ADDR_W'(DEPTH));
    assign v1_c      = pe_mode_c && PE_valid_i_1 && (PE_addr_i_1 < ADDR_W'(DEPTH));
    assign v2_c      = pe_mode_c && PE_valid_i_2 && (PE_addr_i_2 < ADDR_W'(DEPTH));
    assign both_c    = s2_v1_q && s2_v2_q && (s2_addr1_q == s2_addr2_q);

    // Per-lane wrapping sums; on a collision each port's word carries both tiles
    for (genvar gi = 0; gi < TILE; gi++) begin : g_row
        for (genvar gj = 0; gj < TILE; gj++) begin : g_col
            localparam int unsigned BASE = (gi * TILE + gj) * LANE_W;
            assign wr1_c[BASE +: LANE_W] = s2_old1_q[BASE +: LANE_W] + s2_tile1_q[gi][gj]
                                         + (both_c ? s2_tile2_q[gi][gj] : LANE_W'(0));
            assign wr2_c[BASE +: LANE_W] = s2_old2_q[BASE +: LANE_W] + s2_tile2_q[gi][gj]
                                         + (both_c ? s2_tile1_q[gi][gj] : LANE_W'(0));
        end
    end

    assign wr1_c[TAG_LO +: TAG_W]          = both_c ? s2_od2_q : s2_od1_q;
    assign wr2_c[TAG_LO +: TAG_W]          = s2_od2_q;
    assign wr1_c[WORD_W-1:TAG_LO+TAG_W]    = '0;
    assign wr2_c[WORD_W-1:TAG_LO+TAG_W]    = '0;

    // S1 read with forwarding of the word S2 writes this same cycle
    always_comb begin
        old1_c = mem_q[PE_addr_i_1[AW-1:0]];
        old2_c = mem_q[PE_addr_i_2[AW-1:0]];
        if (s2_v2_q && (s2_addr2_q == PE_addr_i_1)) old1_c = wr2_c;
        if (s2_v1_q && (s2_addr1_q == PE_addr_i_1)) old1_c = wr1_c;
        if (s2_v2_q && (s2_addr2_q == PE_addr_i_2)) old2_c = wr2_c;
        if (s2_v1_q && (s2_addr1_q == PE_addr_i_2)) old2_c = wr1_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v1_q    <= 1'b0;
            s2_v2_q    <= 1'b0;
            s2_addr1_q <= '0;
            s2_addr2_q <= '0;
            s2_od1_q   <= '0;
            s2_od2_q   <= '0;
            s2_tile1_q <= '0;
            s2_tile2_q <= '0;
            s2_old1_q  <= '0;
            s2_old2_q  <= '0;
        end else begin
            s2_v1_q <= v1_c;
            s2_v2_q <= v2_c;
            if (v1_c) begin
                s2_addr1_q <= PE_addr_i_1;
                s2_od1_q   <= PE_od_i_1;
                s2_tile1_q <= PE_tile_i_1;
                s2_old1_q  <= old1_c;
            end
            if (v2_c) begin
                s2_addr2_q <= PE_addr_i_2;
                s2_od2_q   <= PE_od_i_2;
                s2_tile2_q <= PE_tile_i_2;
                s2_old2_q  <= old2_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_out <= '0;
        end else if (srd_c) begin
            scan_out <= scan_ok_c ? mem_q[scan_addr[AW-1:0]] : '0;
        end
    end

    // Later assignment wins: S2 commits first, a same-cycle scan write overrides it
    always_ff @(posedge clk) begin
        if (s2_v1_q) mem_q[s2_addr1_q[AW-1:0]] <= wr1_c;
        if (s2_v2_q) mem_q[s2_addr2_q[AW-1:0]] <= wr2_c;
        if (swr_c && scan_ok_c) mem_q[scan_addr[AW-1:0]] <= scan_in;
    end

endmodule

// File: tb/tb_cim_mem_top.sv
// Bench for cim_mem_top: directed dump table for the accumulate/guard corners,
// then randomized traffic checked against a word-level memory model.
`timescale 1ns/1ps
module tb_cim_mem_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [431:0] t1, t2;
    wire  [0:5][0:5][11:0] t1_port, t2_port;
    logic [7:0]   od1, od2, a1, a2, saddr;
    logic         v1, v2;
    logic [511:0] sin;
    logic [1:0]   smode;
    logic [511:0] sout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 6; gi++) begin : g_r
        for (genvar gj = 0; gj < 6; gj++) begin : g_c
            assign t1_port[gi][gj] = t1[(gi*6+gj)*12 +: 12];
            assign t2_port[gi][gj] = t2[(gi*6+gj)*12 +: 12];
        end
    end

    cim_mem_top dut (
        .clk(clk), .rst_n(rst_n),
        .PE_tile_i_1(t1_port), .PE_od_i_1(od1), .PE_addr_i_1(a1), .PE_valid_i_1(v1),
        .PE_tile_i_2(t2_port), .PE_od_i_2(od2), .PE_addr_i_2(a2), .PE_valid_i_2(v2),
        .scan_in(sin), .scan_addr(saddr), .scan_mode(smode), .scan_out(sout)
    );

    // Reference model: array of words, queue of ops awaiting their commit edge
    typedef struct {
        bit           v1, v2;
        logic [7:0]   a1, a2, od1, od2;
        logic [431:0] t1, t2;
    } op_t;

    logic [511:0] mm [128];
    logic [511:0] m_out;
    op_t          pq[$];

    function automatic logic [511:0] add_tile(logic [511:0] w, logic [431:0] t);
        for (int k = 0; k < 36; k++) w[k*12 +: 12] = w[k*12 +: 12] + t[k*12 +: 12];
        return w;
    endfunction

    function automatic logic [511:0] seal(logic [511:0] w, logic [7:0] od);
        w[439:432] = od;
        w[511:440] = '0;
        return w;
    endfunction

    function automatic logic [431:0] fill(logic [11:0] v);
        logic [431:0] f;
        for (int k = 0; k < 36; k++) f[k*12 +: 12] = v;
        return f;
    endfunction

    function automatic logic [511:0] mk(logic [11:0] lane0, logic [11:0] rest, logic [7:0] tag);
        logic [511:0] w = '0;
        for (int k = 0; k < 36; k++) w[k*12 +: 12] = (k == 0) ? lane0 : rest;
        w[439:432] = tag;
        return w;
    endfunction

    function automatic logic [431:0] rnd_tile();
        logic [431:0] f;
        for (int k = 0; k < 36; k++) f[k*12 +: 12] = 12'($urandom);
        return f;
    endfunction

    function automatic logic [511:0] rnd_word();
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [7:0] rnd_addr();
        return ($urandom_range(0, 15) == 0) ? 8'd200 : 8'($urandom_range(0, 7));
    endfunction

    task automatic model_edge();
        op_t          o;
        logic [511:0] rd = '0;
        if (saddr < 8'd128) rd = mm[saddr[6:0]];
        if (smode == 2'b11) m_out = rd;
        while (pq.size() > 0) begin
            o = pq.pop_front();
            if (o.v1 && o.v2 && o.a1 == o.a2) begin
                mm[o.a1[6:0]] = seal(add_tile(add_tile(mm[o.a1[6:0]], o.t1), o.t2), o.od2);
            end else begin
                if (o.v1) mm[o.a1[6:0]] = seal(add_tile(mm[o.a1[6:0]], o.t1), o.od1);
                if (o.v2) mm[o.a2[6:0]] = seal(add_tile(mm[o.a2[6:0]], o.t2), o.od2);
            end
        end
        if (smode == 2'b00 && saddr < 8'd128) mm[saddr[6:0]] = sin;
        if (smode == 2'b01) begin
            o.v1 = v1 && (a1 < 8'd128);
            o.v2 = v2 && (a2 < 8'd128);
            o.a1 = a1; o.a2 = a2; o.od1 = od1; o.od2 = od2; o.t1 = t1; o.t2 = t2;
            if (o.v1 || o.v2) pq.push_back(o);
        end
    endtask

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        smode = 2'b10; v1 = 1'b0; v2 = 1'b0;
        step();
    endtask

    task automatic swrite(logic [7:0] addr, logic [511:0] data);
        smode = 2'b00; saddr = addr; sin = data; v1 = 1'b0; v2 = 1'b0;
        step();
    endtask

    task automatic sread_check(string name, logic [7:0] addr, logic [511:0] exp);
        smode = 2'b11; saddr = addr; v1 = 1'b0; v2 = 1'b0;
        step();
        check(name, sout, exp);
    endtask

    task automatic pe(logic [7:0] pa1, logic [431:0] pt1, logic [7:0] pod1, logic pv1,
                      logic [7:0] pa2, logic [431:0] pt2, logic [7:0] pod2, logic pv2);
        smode = 2'b01;
        a1 = pa1; t1 = pt1; od1 = pod1; v1 = pv1;
        a2 = pa2; t2 = pt2; od2 = pod2; v2 = pv2;
        step();
    endtask

    typedef struct {
        logic [7:0]   addr;
        logic [511:0] exp;
        string        name;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'd3,   mk(12'h0CF, 12'h0CC, 8'h00), "acc_p1_a3"};
        tbl[1]  = '{8'd4,   mk(12'h0E1, 12'h0DD, 8'h01), "acc_p2_a4"};
        tbl[2]  = '{8'd5,   mk(12'h0AF, 12'h0AA, 8'h02), "acc_p1_a5"};
        tbl[3]  = '{8'd6,   mk(12'h0C1, 12'h0BB, 8'h03), "acc_p2_a6"};
        tbl[4]  = '{8'd7,   512'd7,                      "untouched_a7"};
        tbl[5]  = '{8'd10,  mk(12'h002, 12'h002, 8'h00), "back_to_back"};
        tbl[6]  = '{8'd20,  mk(12'h00C, 12'h00C, 8'h09), "collision"};
        tbl[7]  = '{8'd30,  mk(12'h800, 12'h800, 8'h00), "wrap_7ff"};
        tbl[8]  = '{8'd72,  512'd72,                     "oob_no_alias"};
        tbl[9]  = '{8'd40,  512'd40,                     "pe_in_idle"};
        tbl[10] = '{8'd50,  512'd123456,                 "scan_over_s2"};
        tbl[11] = '{8'd51,  mk(12'h035, 12'h002, 8'h04), "mode_change_done"};
        tbl[12] = '{8'd200, 512'd0,                      "read_oob"};
        tbl[13] = '{8'd2,   512'd2,                      "untouched_a2"};

        rst_n = 1'b1; smode = 2'b10; saddr = '0; sin = '0;
        a1 = '0; a2 = '0; od1 = '0; od2 = '0; v1 = 1'b0; v2 = 1'b0; t1 = '0; t2 = '0;
        m_out = '0;
        #2 rst_n = 1'b0;
        #10 check("reset_scan_out", sout, 512'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 128; i++) swrite(8'(i), 512'(i));
        swrite(8'd200, {512{1'b1}});
        for (int i = 0; i < 128; i++) sread_check($sformatf("dump_%0d", i), 8'(i), 512'(i));

        pe(8'd3, fill(12'h0CC), 8'd0, 1'b1, 8'd4, fill(12'h0DD), 8'd1, 1'b1);
        pe(8'd5, fill(12'h0AA), 8'd2, 1'b1, 8'd6, fill(12'h0BB), 8'd3, 1'b1);
        pe(8'd0, '0, 8'd0, 1'b0, 8'd0, '0, 8'd0, 1'b0);
        idle();

        swrite(8'd10, '0);
        pe(8'd10, fill(12'h001), 8'd0, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        pe(8'd10, fill(12'h001), 8'd0, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        idle();

        swrite(8'd20, '0);
        pe(8'd20, fill(12'h005), 8'd2, 1'b1, 8'd20, fill(12'h007), 8'd9, 1'b1);
        idle();

        swrite(8'd30, mk(12'h7FF, 12'h7FF, 8'h00));
        pe(8'd30, fill(12'h001), 8'd0, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        idle();

        pe(8'd200, fill(12'h001), 8'd5, 1'b1, 8'd200, fill(12'h001), 8'd5, 1'b1);
        idle();

        smode = 2'b10; a1 = 8'd40; t1 = fill(12'h001); v1 = 1'b1;
        step();
        idle();

        pe(8'd50, fill(12'h001), 8'd0, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        swrite(8'd50, 512'd123456);

        pe(8'd51, fill(12'h002), 8'd4, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        idle();

        for (int i = 0; i < 14; i++) sread_check(tbl[i].name, tbl[i].addr, tbl[i].exp);

        // Async reset while in scan-read mode with a PE op still in flight
        sread_check("pre_reset_read", 8'd3, mk(12'h0CF, 12'h0CC, 8'h00));
        pe(8'd60, fill(12'h001), 8'd1, 1'b1, 8'd0, '0, 8'd0, 1'b0);
        smode = 2'b11; saddr = 8'd3; v1 = 1'b0;
        rst_n = 1'b0;
        #1 check("reset_async_clear", sout, 512'd0);
        pq.delete();
        m_out = '0;
        @(negedge clk) rst_n = 1'b1;
        sread_check("retain_after_reset", 8'd3, mk(12'h0CF, 12'h0CC, 8'h00));
        sread_check("inflight_dropped", 8'd60, 512'd60);

        for (int i = 0; i < 128; i++) swrite(8'(i), rnd_word());
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 9);
            smode = (r < 5) ? 2'b01 : (r < 7) ? 2'b11 : (r == 7) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            a1 = rnd_addr(); a2 = rnd_addr();
            v1 = 1'($urandom); v2 = 1'($urandom);
            od1 = 8'($urandom); od2 = 8'($urandom);
            t1 = rnd_tile(); t2 = rnd_tile();
            saddr = rnd_addr(); sin = rnd_word();
            step();
            check($sformatf("rand_%0d", n), sout, m_out);
        end
        idle();
        for (int i = 0; i < 8; i++) sread_check($sformatf("final_%0d", i), 8'(i), mm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
